// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Configuration-chain sequencer for an IO grid tile column. Bitstream words
//   arrive over a valid/ready stream and exactly CHAIN_LEN bits are shifted,
//   LSB first, into the chain's ccff_head. An optional verify pass rotates the
//   chain once through ccff_tail and compares a CRC-16-CCITT of the tail bits
//   against the CRC of the loaded bits. Pads stay isolated (IO_ISOL_N=0) until
//   the chain is loaded, verified and settled.
//
// Ports
//   prog_clk     : clock (chain is clocked from it through an external ICG)
//   prog_reset   : synchronous, active-high reset
//   start        : one-cycle pulse, begins a load (only in IDLE or DONE)
//   verify_en    : sampled with start, enables the verify pass
//   in_data      : bitstream word, LSB shifted first
//   in_valid     : word valid
//   in_ready     : word buffer empty and accepting (LOAD only)
//   ccff_head    : serial bit into the chain
//   ccff_tail    : serial bit from the chain end
//   prog_clk_en  : chain clock enable, chain shifts at end of enabled cycle
//   IO_ISOL_N    : 0 = pads isolated
//   busy         : high in LOAD, VERIFY and SETTLE
//   done         : high in DONE
//   crc_err      : verify mismatch, sticky until next start
module ccff_chain_loader #(
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned CHAIN_LEN     = 9,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BUF_CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BUF_CNT_W-1:0] BUF_FULL = BUF_CNT_W'(WORD_W);
  localparam logic [SET_W-1:0]     SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]          CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_SETTLE,
    S_DONE
  } state_t;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t               state_q,   state_d;
  logic [WORD_W-1:0]    buf_q,     buf_d;
  logic [BUF_CNT_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]          crc_q,     crc_d;
  logic [15:0]          ref_crc_q, ref_crc_d;
  logic                 verify_q,  verify_d;
  logic                 crc_err_q, crc_err_d;
  logic [SET_W-1:0]     settle_q,  settle_d;
  logic                 en_q,      en_d;
  logic                 ready_q,   ready_d;
  logic                 isol_n_q,  isol_n_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [15:0]          crc_next;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      bit_cnt_q <= '0;
      crc_q     <= CRC_INIT;
      ref_crc_q <= '0;
      verify_q  <= 1'b0;
      crc_err_q <= 1'b0;
      settle_q  <= '0;
      en_q      <= 1'b0;
      ready_q   <= 1'b0;
      isol_n_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      crc_q     <= crc_d;
      ref_crc_q <= ref_crc_d;
      verify_q  <= verify_d;
      crc_err_q <= crc_err_d;
      settle_q  <= settle_d;
      en_q      <= en_d;
      ready_q   <= ready_d;
      isol_n_q  <= isol_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    bit_cnt_d = bit_cnt_q;
    crc_d     = crc_q;
    ref_crc_d = ref_crc_q;
    verify_d  = verify_q;
    crc_err_d = crc_err_q;
    settle_d  = settle_q;
    crc_next  = crc_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          buf_d     = '0;
          buf_cnt_d = '0;
          bit_cnt_d = '0;
          crc_d     = CRC_INIT;
          crc_err_d = 1'b0;
          verify_d  = verify_en;
        end
      end

      S_LOAD: begin
        if (buf_cnt_q != '0) begin
          crc_next  = crc_step(crc_q, buf_q[0]);
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          crc_d     = crc_next;
          if (bit_cnt_q == LAST_BIT) begin
            // Chain full: drop whatever is left of the current word.
            buf_d     = '0;
            buf_cnt_d = '0;
            bit_cnt_d = '0;
            if (verify_q) begin
              state_d   = S_VERIFY;
              ref_crc_d = crc_next;
              crc_d     = CRC_INIT;
            end else begin
              state_d  = S_SETTLE;
              settle_d = '0;
            end
          end
        end else if (in_valid && ready_q) begin
          buf_d     = in_data;
          buf_cnt_d = BUF_FULL;
        end
      end

      S_VERIFY: begin
        crc_next  = crc_step(crc_q, ccff_tail);
        crc_d     = crc_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          crc_err_d = (crc_next != ref_crc_q);
          bit_cnt_d = '0;
          state_d   = S_SETTLE;
          settle_d  = '0;
        end
      end

      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = S_DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    en_d     = ((state_d == S_LOAD) && (buf_cnt_d != '0)) || (state_d == S_VERIFY);
    ready_d  = (state_d == S_LOAD) && (buf_cnt_d == '0);
    busy_d   = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_SETTLE);
    done_d   = (state_d == S_DONE);
    isol_n_d = (state_d == S_DONE);
  end

  // Loopback in VERIFY rotates the chain in place; elsewhere the head comes
  // straight from the buffer flop (zero whenever the buffer is empty).
  assign ccff_head   = (state_q == S_VERIFY) ? ccff_tail : buf_q[0];
  assign prog_clk_en = en_q;
  assign in_ready    = ready_q;
  assign IO_ISOL_N   = isol_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign crc_err     = crc_err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance (CHAIN_LEN=9)
  logic        start9, ven9, valid9, ready9, head9, tail9, en9, isol9, busy9, done9, err9;
  logic [31:0] data9;
  // Multi-word instance (CHAIN_LEN=40)
  logic        start40, ven40, valid40, ready40, head40, tail40, en40, isol40, busy40, done40, err40;
  logic [31:0] data40;

  ccff_chain_loader dut (
    .prog_clk(clk), .prog_reset(rst), .start(start9), .verify_en(ven9),
    .in_data(data9), .in_valid(valid9), .in_ready(ready9),
    .ccff_head(head9), .ccff_tail(tail9), .prog_clk_en(en9),
    .IO_ISOL_N(isol9), .busy(busy9), .done(done9), .crc_err(err9)
  );

  ccff_chain_loader #(.CHAIN_LEN(40)) dut40 (
    .prog_clk(clk), .prog_reset(rst), .start(start40), .verify_en(ven40),
    .in_data(data40), .in_valid(valid40), .in_ready(ready40),
    .ccff_head(head40), .ccff_tail(tail40), .prog_clk_en(en40),
    .IO_ISOL_N(isol40), .busy(busy40), .done(done40), .crc_err(err40)
  );

  // Behavioural chains: shift on enabled cycles, optional stuck-at-0 on bit 4.
  logic [8:0]  chain9  = '0;
  logic [39:0] chain40 = '0;
  logic [8:0]  nx9;
  logic        stuck4;
  assign tail9  = chain9[8];
  assign tail40 = chain40[39];

  always @(posedge clk) begin
    if (en9) begin
      nx9 = {chain9[7:0], head9};
      if (stuck4) nx9[4] = 1'b0;
      chain9 <= nx9;
    end
    if (en40) chain40 <= {chain40[38:0], head40};
  end

  // Recorder of enabled cycles and handshakes, sampled mid-cycle.
  logic        rec_clr;
  int          cyc = 0;
  int          en9_cnt = 0, en40_cnt = 0, acc40 = 0, last_en9 = 0;
  logic [63:0] hbits9 = '0, hbits40 = '0;

  always @(negedge clk) begin
    cyc++;
    if (rec_clr) begin
      en9_cnt = 0; en40_cnt = 0; acc40 = 0; hbits9 = '0; hbits40 = '0;
    end else begin
      if (en9) begin
        if (en9_cnt < 64) hbits9[en9_cnt] = head9;
        en9_cnt++;
        last_en9 = cyc;
      end
      if (en40) begin
        if (en40_cnt < 64) hbits40[en40_cnt] = head40;
        en40_cnt++;
      end
      if (valid40 && ready40) acc40++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    rec_clr = 1'b1;
    tick();
    rec_clr = 1'b0;
  endtask

  // Start a single-word load on the 9-bit instance and wait for done.
  // lat counts cycles from the start cycle to the first cycle with done=1.
  task automatic run9(input logic ven, input logic [31:0] d, input int restart_at,
                      output int lat);
    start9 = 1'b1; ven9 = ven; data9 = d; valid9 = 1'b1; lat = 0;
    tick(); lat = 1; start9 = 1'b0;
    for (int i = 0; i < 200 && !done9; i++) begin
      if (lat == 2) valid9 = 1'b0;
      start9 = (lat == restart_at);
      tick(); lat++;
    end
    start9 = 1'b0;
  endtask

  int lat;
  int snap;

  initial begin
    rst = 1'b1; rec_clr = 1'b0; stuck4 = 1'b0;
    start9 = 0; ven9 = 0; valid9 = 0; data9 = '0;
    start40 = 0; ven40 = 0; valid40 = 0; data40 = '0;
    tick(); tick(); tick();

    // Reset values
    check("rst_isol", isol9, 0);
    check("rst_en", en9, 0);
    check("rst_head", head9, 0);
    check("rst_ready", ready9, 0);
    check("rst_busy", busy9, 0);
    check("rst_done", done9, 0);
    check("rst_err", err9, 0);
    check("rst_isol40", isol40, 0);
    rst = 1'b0;
    tick();
    clr();

    // Basic load, verify off
    run9(1'b0, 32'h0000_01A5, -1, lat);
    check("basic_done", done9, 1);
    check("basic_latency", lat, 15);
    check("basic_settle_gap", cyc - last_en9, 4);
    check("basic_en_cnt", en9_cnt, 9);
    check("basic_head_bits", hbits9[8:0], 9'h1A5);
    check("basic_chain", chain9, 9'h14B);
    check("basic_isol", isol9, 1);
    check("basic_busy", busy9, 0);
    check("basic_err", err9, 0);
    clr();

    // Verify pass, good chain
    run9(1'b1, 32'h0000_01A5, -1, lat);
    check("ver_done", done9, 1);
    check("ver_latency", lat, 24);
    check("ver_err", err9, 0);
    check("ver_en_cnt", en9_cnt, 18);
    check("ver_head_bits", hbits9[17:0], {9'h1A5, 9'h1A5});
    check("ver_chain", chain9, 9'h14B);
    check("ver_isol", isol9, 1);
    clr();

    // Verify mismatch with bit 4 stuck at 0
    stuck4 = 1'b1;
    run9(1'b1, 32'h0000_01FF, -1, lat);
    check("mis_done", done9, 1);
    check("mis_err", err9, 1);
    check("mis_isol", isol9, 1);
    // Next start clears the error and re-isolates
    start9 = 1'b1; ven9 = 1'b0; valid9 = 1'b1; data9 = 32'h0000_01FF;
    tick();
    start9 = 1'b0;
    check("mis_clr_err", err9, 0);
    check("mis_clr_busy", busy9, 1);
    check("mis_clr_isol", isol9, 0);
    check("mis_clr_done", done9, 0);
    tick();
    valid9 = 1'b0;
    for (int i = 0; i < 200 && !done9; i++) tick();
    check("mis2_done", done9, 1);
    check("mis2_err", err9, 0);
    stuck4 = 1'b0;
    clr();

    // start pulsed mid-LOAD is ignored
    run9(1'b0, 32'h0000_01A5, 4, lat);
    check("midstart_latency", lat, 15);
    check("midstart_en_cnt", en9_cnt, 9);
    check("midstart_head_bits", hbits9[8:0], 9'h1A5);
    clr();

    // Reset mid-VERIFY
    start9 = 1'b1; ven9 = 1'b1; data9 = 32'h0000_01A5; valid9 = 1'b1;
    tick();
    start9 = 1'b0;
    tick();
    valid9 = 1'b0;
    for (int i = 0; i < 100 && en9_cnt < 12; i++) tick();
    check("rv_reached_verify", (en9_cnt >= 12), 1);
    check("rv_busy_before", busy9, 1);
    rst = 1'b1;
    tick();
    check("rv_isol", isol9, 0);
    check("rv_en", en9, 0);
    check("rv_head", head9, 0);
    check("rv_ready", ready9, 0);
    check("rv_busy", busy9, 0);
    check("rv_done", done9, 0);
    check("rv_err", err9, 0);
    rst = 1'b0;
    tick();
    clr();
    run9(1'b1, 32'h0000_01A5, -1, lat);
    check("rv_fresh_done", done9, 1);
    check("rv_fresh_err", err9, 0);
    check("rv_fresh_chain", chain9, 9'h14B);
    check("rv_fresh_en_cnt", en9_cnt, 18);
    clr();

    // Multi-word chain, 5-cycle stall between words, third word refused
    start40 = 1'b1; ven40 = 1'b0; valid40 = 1'b1; data40 = 32'hFFFF_FFFF;
    tick();
    start40 = 1'b0;
    tick();
    valid40 = 1'b0;
    for (int i = 0; i < 100 && !ready40; i++) tick();
    check("mw_ready_again", ready40, 1);
    snap = en40_cnt;
    check("mw_first_word_bits", snap, 32);
    for (int i = 0; i < 5; i++) tick();
    check("mw_gap_no_en", en40_cnt, snap);
    check("mw_gap_ready", ready40, 1);
    valid40 = 1'b1; data40 = 32'h0000_00AA;
    tick();
    data40 = 32'h1234_5678;
    for (int i = 0; i < 200 && !done40; i++) tick();
    valid40 = 1'b0;
    check("mw_done", done40, 1);
    check("mw_en_cnt", en40_cnt, 40);
    check("mw_word1_bits", hbits40[31:0], 32'hFFFF_FFFF);
    check("mw_word2_bits", hbits40[39:32], 8'hAA);
    check("mw_accepts", acc40, 2);
    check("mw_chain", chain40, {32'hFFFF_FFFF, 8'h55});
    check("mw_isol", isol40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
